// File: rtl/proc_muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// operation encodings, FSM states and the request message layout.
package proc_muldiv_pkg;

    // Operation select encodings carried on req_fn
    localparam logic [2:0] MULDIV_FN_MUL   = 3'd0;  // low half, sign-agnostic
    localparam logic [2:0] MULDIV_FN_MULH  = 3'd1;  // signed x signed, high half
    localparam logic [2:0] MULDIV_FN_MULHU = 3'd2;  // unsigned x unsigned, high half
    localparam logic [2:0] MULDIV_FN_DIV   = 3'd3;
    localparam logic [2:0] MULDIV_FN_DIVU  = 3'd4;
    localparam logic [2:0] MULDIV_FN_REM   = 3'd5;
    localparam logic [2:0] MULDIV_FN_REMU  = 3'd6;
    localparam logic [2:0] MULDIV_FN_RSVD  = 3'd7;

    // Processor word width the request message is laid out for; the unit
    // itself is width-generic.
    localparam int MULDIV_XLEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    typedef struct packed {
        logic [2:0]             fn;
        logic [MULDIV_XLEN-1:0] a;
        logic [MULDIV_XLEN-1:0] b;
    } muldiv_req_msg_t;

endpackage

// File: rtl/proc_muldiv_iter_dpath.sv
// Datapath of the iterative mul/div unit: operand magnitudes, the 2N-bit
// accumulator, shift-add multiply, restoring divide and sign correction.
// Build option PROC_MULDIV_EARLY_TERM_EN enables early multiply exit.
module proc_muldiv_iter_dpath
    import proc_muldiv_pkg::*;
#(
    parameter int p_nbits = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ld,          // accept a regular op
    input  logic               ld_special,  // accept a div-by-zero / reserved op
    input  logic               step,        // one radix-2 iteration
    input  logic               fin,         // last iteration: capture result
    input  logic [2:0]         req_fn,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               early_done,
    output logic [p_nbits-1:0] result
);
    localparam int W2 = 2 * p_nbits;

    logic [2:0]         fn_q, fn_d;
    logic               qneg_q, qneg_d;   // product / quotient sign
    logic               rneg_q, rneg_d;   // remainder sign (follows dividend)
    logic [W2-1:0]      acc_q, acc_d;     // product, or {remainder, quotient}
    logic [W2-1:0]      opb_q, opb_d;     // shifting multiplicand, or divisor
    logic [p_nbits-1:0] mplr_q, mplr_d;   // unconsumed multiplier bits
    logic [p_nbits-1:0] result_q, result_d;

    logic               signed_fn, a_neg, b_neg, req_is_mul, is_mul;
    logic [p_nbits-1:0] a_mag, b_mag;
    logic [W2-1:0]      mul_acc, div_acc, step_acc, prod;
    logic [W2:0]        div_sh;
    logic [p_nbits:0]   div_diff;
    logic [p_nbits-1:0] quo, rem, fin_result, special_result;

    // Operand magnitudes and signs for the incoming request
    always_comb begin
        signed_fn  = (req_fn == MULDIV_FN_MUL) || (req_fn == MULDIV_FN_MULH) ||
                     (req_fn == MULDIV_FN_DIV) || (req_fn == MULDIV_FN_REM);
        a_neg      = signed_fn & req_a[p_nbits-1];
        b_neg      = signed_fn & req_b[p_nbits-1];
        a_mag      = a_neg ? -req_a : req_a;
        b_mag      = b_neg ? -req_b : req_b;
        req_is_mul = (req_fn <= MULDIV_FN_MULHU);
        special_result = '0;
        case (req_fn)
            MULDIV_FN_DIV, MULDIV_FN_DIVU: special_result = '1;
            MULDIV_FN_REM, MULDIV_FN_REMU: special_result = req_a;
            default:                       special_result = '0;
        endcase
    end

    // One iteration step plus the sign-corrected final result
    always_comb begin
        is_mul   = (fn_q <= MULDIV_FN_MULHU);
        mul_acc  = acc_q + (mplr_q[0] ? opb_q : '0);
        div_sh   = {acc_q, 1'b0};
        div_diff = div_sh[W2:p_nbits] - {1'b0, opb_q[p_nbits-1:0]};
        div_acc  = div_diff[p_nbits] ? div_sh[W2-1:0]
                                     : {div_diff[p_nbits-1:0], div_sh[p_nbits-1:1], 1'b1};
        step_acc = is_mul ? mul_acc : div_acc;
        prod     = qneg_q ? -step_acc : step_acc;
        quo      = step_acc[p_nbits-1:0];
        rem      = step_acc[W2-1:p_nbits];
        case (fn_q)
            MULDIV_FN_MUL:                   fin_result = prod[p_nbits-1:0];
            MULDIV_FN_MULH, MULDIV_FN_MULHU: fin_result = prod[W2-1:p_nbits];
            MULDIV_FN_DIV, MULDIV_FN_DIVU:   fin_result = qneg_q ? -quo : quo;
            MULDIV_FN_REM, MULDIV_FN_REMU:   fin_result = rneg_q ? -rem : rem;
            default:                         fin_result = '0;
        endcase
    end

`ifdef PROC_MULDIV_EARLY_TERM_EN
    // Product is complete once no multiplier bits remain after this step
    assign early_done = is_mul & (mplr_q[p_nbits-1:1] == '0);
`else
    assign early_done = 1'b0;
`endif

    // Next-state selection for operand, accumulator and result registers
    always_comb begin
        fn_d     = fn_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        mplr_d   = mplr_q;
        result_d = result_q;
        if (ld) begin
            fn_d   = req_fn;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            if (req_is_mul) begin
                acc_d  = '0;
                opb_d  = W2'(a_mag);
                mplr_d = b_mag;
            end else begin
                acc_d  = W2'(a_mag);
                opb_d  = W2'(b_mag);
                mplr_d = '0;
            end
        end else if (step) begin
            acc_d  = step_acc;
            opb_d  = is_mul ? (opb_q << 1) : opb_q;
            mplr_d = mplr_q >> 1;
        end
        if (fin)        result_d = fin_result;
        if (ld_special) result_d = special_result;
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fn_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            acc_q    <= '0;
            opb_q    <= '0;
            mplr_q   <= '0;
            result_q <= '0;
        end else begin
            fn_q     <= fn_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            mplr_q   <= mplr_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/proc_muldiv_iter_unit.sv
// Iterative multiply/divide unit for the X stage: FSM, iteration counter and
// val/rdy handshakes around proc_muldiv_iter_dpath.
// Build option PROC_MULDIV_EARLY_TERM_EN lets multiplies leave CALC early.
module proc_muldiv_iter_unit
    import proc_muldiv_pkg::*;
#(
    parameter int p_nbits    = 32,
    parameter int p_cnt_bits = $clog2(p_nbits) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_val,
    output logic               req_rdy,
    input  logic [2:0]         req_fn,
    input  logic [p_nbits-1:0] req_a,
    input  logic [p_nbits-1:0] req_b,
    output logic               resp_val,
    input  logic               resp_rdy,
    output logic [p_nbits-1:0] resp_result,
    output logic               busy
);
    muldiv_state_e         state_q, state_d;
    logic [p_cnt_bits-1:0] cnt_q, cnt_d;

    logic accept, req_is_div, special, last, step, fin, ld, ld_special, early_done;

    // Accept / special-case decode and iteration termination
    always_comb begin
        accept     = (state_q == ST_IDLE) & req_val;
        req_is_div = (req_fn >= MULDIV_FN_DIV) && (req_fn <= MULDIV_FN_REMU);
        special    = (req_fn == MULDIV_FN_RSVD) | (req_is_div & (req_b == '0));
        ld         = accept & ~special;
        ld_special = accept & special;
        step       = (state_q == ST_CALC);
        last       = (cnt_q == p_cnt_bits'(1)) | early_done;
        fin        = step & last;
    end

    // FSM and iteration counter next state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: if (accept) begin
                state_d = special ? ST_DONE : ST_CALC;
                cnt_d   = p_cnt_bits'(p_nbits);
            end
            ST_CALC: begin
                cnt_d = cnt_q - p_cnt_bits'(1);
                if (last) state_d = ST_DONE;
            end
            ST_DONE: if (resp_rdy) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Control state registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    proc_muldiv_iter_dpath #(.p_nbits(p_nbits)) u_dpath (
        .clk        (clk),
        .rst        (reset),
        .ld         (ld),
        .ld_special (ld_special),
        .step       (step),
        .fin        (fin),
        .req_fn     (req_fn),
        .req_a      (req_a),
        .req_b      (req_b),
        .early_done (early_done),
        .result     (resp_result)
    );

    assign req_rdy  = (state_q == ST_IDLE);
    assign resp_val = (state_q == ST_DONE);
    assign busy     = (state_q != ST_IDLE);

endmodule
